// File: rtl/melody_sequencer_if.sv
//------------------------------------------------------------------------------
// melody_sequencer_if : control, pattern-write and note-output bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface melody_sequencer_if #(
    parameter int NUM_STEPS = 16
);
    localparam int c_aw = $clog2(NUM_STEPS);

    logic            start;
    logic            stop;
    logic            loop_en;
    logic            wr_en;
    logic [c_aw-1:0] wr_addr;
    logic [7:0]      wr_data;
    logic [1:0]      tone_sel;
    logic            octave_dena;
    logic            octave_uena;
    logic            tremolo_ena;
    logic            led_ena;
    logic [c_aw-1:0] step_o;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_data,
        input  tone_sel, octave_dena, octave_uena, tremolo_ena, led_ena,
               step_o, busy, done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_data,
        output tone_sel, octave_dena, octave_uena, tremolo_ena, led_ena,
               step_o, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/melody_sequencer.sv
//------------------------------------------------------------------------------
// melody_sequencer : 16-step melody player driving the tone/feature datapath
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module melody_sequencer #(
    parameter int TICK_DIV  = 4,
    parameter int GAP_CYC   = 2,
    parameter int NUM_STEPS = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    melody_sequencer_if.slave bus
);
    localparam int c_aw      = $clog2(NUM_STEPS);
    localparam int c_max_cnt = (8 * TICK_DIV > GAP_CYC) ? 8 * TICK_DIV : GAP_CYC;
    localparam int c_cw      = $clog2(c_max_cnt + 1);

    localparam logic [c_aw-1:0] c_last_step = c_aw'(NUM_STEPS - 1);
    localparam logic [c_cw-1:0] c_gap_last  = c_cw'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [1:0]      c_tone_rest = 2'b00;
    localparam logic [1:0]      c_tone_end  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [NUM_STEPS];
    logic [c_aw-1:0] r_step;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] r_play_last;
    logic [1:0]      r_tone_sel;
    logic            r_octave_dena;
    logic            r_octave_uena;
    logic            r_tremolo_ena;
    logic            r_led_ena;
    logic            r_busy;
    logic            r_done;

    logic [7:0]      w_word;
    logic            w_sound;
    logic [c_cw-1:0] w_word_last;
    state_t          w_adv_state;
    logic [c_aw-1:0] w_adv_step;

    assign w_word      = r_mem[r_step];
    assign w_sound     = (w_word[7:6] != c_tone_rest);
    assign w_word_last = c_cw'((int'(w_word[2:0]) + 1) * TICK_DIV - 1);

    // Where playback goes after a note (and its gap) has finished.
    always_comb begin
        w_adv_state = S_LOAD;
        w_adv_step  = r_step + 1'b1;
        if (r_step == c_last_step) begin
            w_adv_step = '0;
            if (!bus.loop_en) begin
                w_adv_state = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_mem[i] <= 8'hC0;
            end
        end else if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_step        <= '0;
            r_cnt         <= '0;
            r_play_last   <= '0;
            r_tone_sel    <= 2'b00;
            r_octave_dena <= 1'b0;
            r_octave_uena <= 1'b0;
            r_tremolo_ena <= 1'b0;
            r_led_ena     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop && (r_state != S_IDLE)) begin
                r_state       <= S_IDLE;
                r_step        <= '0;
                r_tone_sel    <= 2'b00;
                r_octave_dena <= 1'b0;
                r_octave_uena <= 1'b0;
                r_tremolo_ena <= 1'b0;
                r_led_ena     <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            r_state <= S_LOAD;
                            r_step  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (w_word[7:6] == c_tone_end) begin
                            // An end marker at step 0 while looping would spin forever.
                            if (bus.loop_en && (r_step != '0)) begin
                                r_step <= '0;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_state       <= S_PLAY;
                            r_cnt         <= '0;
                            r_play_last   <= w_word_last;
                            r_tone_sel    <= w_word[7:6];
                            r_octave_dena <= w_sound & w_word[5] & ~w_word[4];
                            r_octave_uena <= w_sound & w_word[4] & ~w_word[5];
                            r_tremolo_ena <= w_sound & w_word[3];
                            r_led_ena     <= w_sound;
                        end
                    end
                    S_PLAY: begin
                        if (r_cnt == r_play_last) begin
                            r_cnt         <= '0;
                            r_tone_sel    <= 2'b00;
                            r_octave_dena <= 1'b0;
                            r_octave_uena <= 1'b0;
                            r_tremolo_ena <= 1'b0;
                            r_led_ena     <= 1'b0;
                            if (GAP_CYC > 0) begin
                                r_state <= S_GAP;
                            end else begin
                                r_state <= w_adv_state;
                                r_step  <= w_adv_step;
                                r_done  <= (w_adv_state == S_DONE);
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == c_gap_last) begin
                            r_cnt   <= '0;
                            r_state <= w_adv_state;
                            r_step  <= w_adv_step;
                            r_done  <= (w_adv_state == S_DONE);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_step  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tone_sel    = r_tone_sel;
    assign bus.octave_dena = r_octave_dena;
    assign bus.octave_uena = r_octave_uena;
    assign bus.tremolo_ena = r_tremolo_ena;
    assign bus.led_ena     = r_led_ena;
    assign bus.step_o      = r_step;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
//------------------------------------------------------------------------------
// tb_melody_sequencer : directed self-checking bench for melody_sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_melody_sequencer;
    localparam int c_guard = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    melody_sequencer_if #(.NUM_STEPS(16)) bus ();

    melody_sequencer #(
        .TICK_DIV  (4),
        .GAP_CYC   (2),
        .NUM_STEPS (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [5:0] exp_out;   // {tone_sel, octave_dena, octave_uena, tremolo_ena, led_ena}
        int         exp_busy;
        int         exp_led;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [5:0] outs();
        return {bus.tone_sel, bus.octave_dena, bus.octave_uena, bus.tremolo_ena, bus.led_ena};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starts playback and follows it until busy drops, returning what was observed.
    task automatic play_measure(output int busy_cyc, output int led_cyc,
                                output int done_cyc, output logic [5:0] first_out);
        int k;
        busy_cyc  = 0;
        led_cyc   = 0;
        done_cyc  = 0;
        first_out = '0;
        k         = 0;
        pulse_start();
        while (bus.busy && (k < c_guard)) begin
            if (k == 1) first_out = outs();
            busy_cyc += 1;
            led_cyc  += int'(bus.led_ena);
            done_cyc += int'(bus.done);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_step(input logic [3:0] target, output int seen_done, output bit ok);
        int k;
        k = 0;
        seen_done = 0;
        while ((bus.step_o != target) && (k < c_guard)) begin
            @(negedge clk);
            seen_done += int'(bus.done);
            k++;
        end
        ok = (bus.step_o == target);
    endtask

    initial begin
        int         busy_cyc, led_cyc, done_cyc, dn;
        logic [5:0] first_out;
        bit         ok;

        vecs[0] = '{8'h41, 6'b010001, 13, 8};
        vecs[1] = '{8'hA8, 6'b101011,  9, 4};
        vecs[2] = '{8'h70, 6'b010001,  9, 4};
        vecs[3] = '{8'h57, 6'b010101, 37, 32};
        vecs[4] = '{8'h0B, 6'b000000, 21, 0};
        vecs[5] = '{8'h98, 6'b100111,  9, 4};
        vecs[6] = '{8'h8F, 6'b100011, 37, 32};
        vecs[7] = '{8'hC0, 6'b000000,  2, 0};

        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_outs", outs(), 6'b0);
        check("reset_busy_done", {bus.busy, bus.done}, 2'b00);
        check("reset_step", bus.step_o, 4'd0);

        play_measure(busy_cyc, led_cyc, done_cyc, first_out);
        check("empty_busy", busy_cyc, 2);
        check("empty_done", done_cyc, 1);
        check("empty_outs", first_out, 6'b0);

        for (int i = 0; i < 8; i++) begin
            write_mem(4'd0, vecs[i].word);
            write_mem(4'd1, 8'hC0);
            play_measure(busy_cyc, led_cyc, done_cyc, first_out);
            check($sformatf("vec%0d_outs", i), first_out, vecs[i].exp_out);
            check($sformatf("vec%0d_busy", i), busy_cyc, vecs[i].exp_busy);
            check($sformatf("vec%0d_led", i), led_cyc, vecs[i].exp_led);
            check($sformatf("vec%0d_done", i), done_cyc, 1);
        end

        // Loop and wrap across the last step.
        for (int a = 0; a < 16; a++) write_mem(4'(a), 8'h40);
        bus.loop_en = 1'b1;
        pulse_start();
        wait_step(4'd15, dn, ok);
        check("loop_reach15", ok, 1'b1);
        wait_step(4'd0, dn, ok);
        check("loop_wrap0", ok, 1'b1);
        check("loop_no_done", dn, 0);
        check("loop_busy", bus.busy, 1'b1);
        wait_step(4'd15, dn, ok);
        bus.loop_en = 1'b0;
        done_cyc = 0;
        for (int k = 0; k < 30 && bus.busy; k++) begin
            @(negedge clk);
            done_cyc += int'(bus.done);
        end
        check("loop_exit_done", done_cyc, 1);
        check("loop_exit_idle", bus.busy, 1'b0);

        // Stop in the middle of a long note.
        write_mem(4'd0, 8'h47);
        pulse_start();
        repeat (5) @(negedge clk);
        check("stop_pre_tone", bus.tone_sel, 2'b01);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_outs", outs(), 6'b0);
        check("stop_busy_step", {bus.busy, bus.step_o}, 5'b0);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            dn += int'(bus.done) + int'(bus.busy);
        end
        check("stop_no_done", dn, 0);

        // start and stop together from IDLE.
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("startstop_idle", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("startstop_still_idle", {bus.busy, bus.tone_sel}, 3'b0);

        // Rewriting the playing step leaves the current note untouched.
        pulse_start();
        repeat (3) @(negedge clk);
        write_mem(4'd0, 8'h80);
        check("rewrite_hold", outs(), 6'b010001);
        repeat (3) @(negedge clk);
        check("rewrite_hold_later", outs(), 6'b010001);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        play_measure(busy_cyc, led_cyc, done_cyc, first_out);
        check("rewrite_next_load", first_out, 6'b100001);

        // Write to the step being loaded: LOAD sees the old word.
        write_mem(4'd0, 8'h41);
        pulse_start();
        write_mem(4'd0, 8'hC0);
        check("readfirst_tone", outs(), 6'b010001);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;

        // Asynchronous reset mid-note.
        write_mem(4'd0, 8'h47);
        pulse_start();
        repeat (4) @(negedge clk);
        check("areset_pre_led", bus.led_ena, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_outs", outs(), 6'b0);
        check("areset_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        play_measure(busy_cyc, led_cyc, done_cyc, first_out);
        check("areset_empty_busy", busy_cyc, 2);
        check("areset_empty_done", done_cyc, 1);
        check("areset_empty_led", led_cyc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
